// File: rtl/mips_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flushes and MDU front-end freeze.
// Optional stall statistics counter is built when HAZARD_STATS_EN is defined.
module mips_hazard_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_memread,
    input  logic             i_ex_branch_taken,
    input  logic             i_ex_mdu_start,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_flush,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic {
        RUN,
        MDU_WAIT
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MDU_LATENCY - 1);

    state_t     state_reg, state_next;
    logic [3:0] wait_cnt_reg, wait_cnt_next;
    logic       load_use;

    // $0 is hard-wired, so a load targeting it can never feed a consumer.
    assign load_use = i_ex_memread && (i_ex_rd != 5'd0) &&
                      ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        o_pc_en       = 1'b1;
        o_ifid_en     = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_en     = 1'b1;
        o_idex_flush  = 1'b0;
        o_busy        = 1'b0;

        if (!i_rst_n) begin
            o_pc_en      = 1'b0;
            o_ifid_en    = 1'b0;
            o_idex_en    = 1'b0;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else begin
            case (state_reg)
                RUN: begin
                    if (i_ex_branch_taken) begin
                        o_ifid_flush = 1'b1;
                        o_idex_flush = 1'b1;
                    end else if (i_ex_mdu_start) begin
                        o_pc_en       = 1'b0;
                        o_ifid_en     = 1'b0;
                        o_idex_en     = 1'b0;
                        state_next    = MDU_WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end else if (load_use) begin
                        o_pc_en      = 1'b0;
                        o_ifid_en    = 1'b0;
                        o_idex_flush = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    o_pc_en       = 1'b0;
                    o_ifid_en     = 1'b0;
                    o_idex_en     = 1'b0;
                    o_busy        = 1'b1;
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                    // Counting the start cycle, the freeze lasts MDU_LATENCY cycles in total.
                    if (wait_cnt_reg <= 4'd1) begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt_reg <= '0;
        end else if (!o_pc_en && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_stall_cnt = stall_cnt_reg;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Self-checking bench for mips_hazard_ctrl: directed scenarios followed by random traffic
// compared against a cycle-level reference model of the hazard rules.
module tb_mips_hazard_ctrl;

    localparam int LAT     = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [4:0]       i_id_rs, i_id_rt, i_ex_rd;
    logic             i_id_uses_rt, i_ex_memread, i_ex_branch_taken, i_ex_mdu_start;
    logic             o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush, o_busy;
    logic [CNT_W-1:0] o_stall_cnt;

    mips_hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_uses_rt(i_id_uses_rt),
        .i_ex_rd(i_ex_rd), .i_ex_memread(i_ex_memread),
        .i_ex_branch_taken(i_ex_branch_taken), .i_ex_mdu_start(i_ex_mdu_start),
        .o_pc_en(o_pc_en), .o_ifid_en(o_ifid_en), .o_ifid_flush(o_ifid_flush),
        .o_idex_en(o_idex_en), .o_idex_flush(o_idex_flush), .o_busy(o_busy),
        .o_stall_cnt(o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int fails  = 0;
    // Reference model: remaining frozen cycles after the current one, and stall tally.
    int frozen_left = 0;
    int stalls      = 0;

    // Control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, busy}
    function automatic logic [5:0] model_ctrl(input logic rst_n, input logic [4:0] rs,
            input logic [4:0] rt, input logic uses_rt, input logic [4:0] rd,
            input logic memread, input logic br, input logic mdu, input int left);
        logic hazard;
        hazard = memread && rd != 0 && (rd == rs || (uses_rt && rd == rt));
        if (!rst_n)       return 6'b001010;
        else if (left > 0) return 6'b000001;
        else if (br)       return 6'b111110;
        else if (mdu)      return 6'b000000;
        else if (hazard)   return 6'b000110;
        else               return 6'b110100;
    endfunction

    task automatic step(input logic rst_n, input logic [4:0] rs, input logic [4:0] rt,
            input logic uses_rt, input logic [4:0] rd, input logic memread,
            input logic br, input logic mdu, input string tag);
        logic [5:0] exp_c, obs_c;
        int         exp_s;
        i_rst_n = rst_n; i_id_rs = rs; i_id_rt = rt; i_id_uses_rt = uses_rt;
        i_ex_rd = rd; i_ex_memread = memread; i_ex_branch_taken = br; i_ex_mdu_start = mdu;
        #1;
        exp_c = model_ctrl(rst_n, rs, rt, uses_rt, rd, memread, br, mdu, frozen_left);
        obs_c = {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush, o_busy};
`ifdef HAZARD_STATS_EN
        exp_s = stalls;
`else
        exp_s = 0;
`endif
        checks++;
        assert (obs_c === exp_c) else begin
            fails++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs_c, exp_c);
        end
        checks++;
        assert (o_stall_cnt === CNT_W'(exp_s)) else begin
            fails++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, o_stall_cnt, exp_s);
        end
        $display("step %-12s rst_n=%b br=%b mdu=%b mr=%b rd=%0d rs=%0d rt=%0d u=%b ctrl=%b cnt=%0d",
                 tag, rst_n, br, mdu, memread, rd, rs, rt, uses_rt, obs_c, o_stall_cnt);
        @(posedge i_clk);
        if (!rst_n) begin
            frozen_left = 0;
            stalls      = 0;
        end else begin
            if (!exp_c[5] && stalls < CNT_MAX) stalls++;
            if (frozen_left > 0)  frozen_left--;
            else if (!br && mdu)  frozen_left = LAT - 1;
        end
        @(negedge i_clk);
    endtask

    initial begin
        @(negedge i_clk);
        step(0, 0, 0, 0, 0, 0, 0, 0, "reset");
        step(0, 8, 0, 0, 8, 1, 1, 1, "reset_force");
        step(1, 1, 2, 1, 3, 0, 0, 0, "idle");
        // Load-use on rs, then the re-evaluated cycle with the load gone
        step(1, 8, 2, 0, 8, 1, 0, 0, "lu_rs");
        step(1, 8, 2, 0, 5, 0, 0, 0, "lu_after");
        step(1, 0, 0, 1, 0, 1, 0, 0, "lu_r0");
        step(1, 4, 9, 0, 9, 1, 0, 0, "rt_unused");
        step(1, 4, 9, 1, 9, 1, 0, 0, "lu_rt");
        // Branch beats load-use and mdu_start
        step(1, 8, 2, 0, 8, 1, 1, 1, "br_prio");
        step(1, 1, 2, 0, 3, 0, 0, 0, "br_after");
        // MDU freeze with a branch arriving mid-wait
        step(1, 1, 2, 0, 3, 0, 0, 1, "mdu_start");
        step(1, 1, 2, 0, 3, 0, 0, 0, "mdu_w1");
        step(1, 1, 2, 0, 3, 0, 1, 0, "mdu_w2_br");
        step(1, 8, 2, 0, 8, 1, 0, 1, "mdu_w3");
        step(1, 1, 2, 0, 3, 0, 0, 0, "mdu_done");
        // Reset during the second wait cycle
        step(1, 1, 2, 0, 3, 0, 0, 1, "mdu2_start");
        step(1, 1, 2, 0, 3, 0, 0, 0, "mdu2_w1");
        step(0, 1, 2, 0, 3, 0, 0, 0, "mdu2_rst");
        step(1, 1, 2, 0, 3, 0, 0, 0, "post_rst");
        step(1, 1, 2, 0, 3, 0, 0, 0, "post_rst2");
        // Five stalls saturate a 2-bit counter
        step(1, 7, 0, 0, 7, 1, 0, 0, "sat1");
        step(1, 7, 0, 0, 7, 1, 0, 0, "sat2");
        step(1, 7, 0, 0, 7, 1, 0, 0, "sat3");
        step(1, 7, 0, 0, 7, 1, 0, 0, "sat4");
        step(1, 7, 0, 0, 7, 1, 0, 0, "sat5");
        step(1, 1, 2, 0, 3, 0, 0, 0, "sat_hold");
        step(0, 1, 2, 0, 3, 0, 0, 0, "sat_rst");
        step(1, 1, 2, 0, 3, 0, 0, 0, "sat_clear");
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), "random");
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
